rvv_alu_wrapper: RTL and testbench
==================================

Name: rvv_alu_wrapper

Overview:
Multi-lane vector ALU sequencer for the RVV extension of the picorv32-based core. It takes two full vector-register operands plus SEW, and streams the vector through 1<<NB_LANES lanes of 8<<… bits each. Each cycle it emits per-lane result chunks, each tagged with the destination bit offset, for the register-file writeback logic. `done_out` flags completion.

Parameters:
- VLEN, 128: vector register length in bits; 10-bit values, max 1023.
- LANE_WIDTH, 3: log2 of lane datapath width in bits; legal 3..6, giving 8..64-bit lanes.
- NB_LANES, 1: log2 of the instantiated lane count; legal 0..2, giving 1..4 lanes.

Ports:
- clk  in  1  clock; rising edge active
- resetn  in  1  asynchronous active-low reset
- opcode  in  6  funct6: VADD=000000, VAND=001001, VOR=001010, VXOR=001011
- run  in  1  start/hold request
- vs1  in  VLEN  operand 1. For VV it is a full vector; for VX/VI it holds the scalar or immediate, sign-extended, in the low bits.
- vs2  in  VLEN  operand 2, vector
- vsew  in  3  SEW = 8<<vsew; legal values 0..3
- op_type  in  3  one-hot: VV=001, VX=010, VI=100
- vd  out  256  four 64-bit lane slots; lane i occupies vd[64*i +: 64]
- regi  out  40  four 10-bit fields; lane i uses regi[10*i +: 10], the destination bit offset of that lane's chunk in the vector
- res  out  4  per-lane "slot valid this cycle"
- done_out  out  1  operation complete

Behaviour:
- Definitions:
  - LW = 1<<LANE_WIDTH.
  - CW (chunk width) = min(SEW, LW).
  - E = VLEN/SEW elements.
  - A (active lanes) = min(E, 1<<NB_LANES), a power of two.
  - N (steps) = (VLEN/CW)/A.
- Reset (async, resetn=0):
  - vd=0, regi=0, res=0, done_out=0.
  - State goes to IDLE; step counter and carry registers clear.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY: at a rising edge with run=1.
  - That same edge registers step-0 results on the outputs.
  - Inputs must stay stable while BUSY.
- BUSY, step j (0..N-1):
  - Lanes k < A have res[k]=1; lanes k >= A have res[k]=0 and their slot/regi fields are 0.
  - Lane k processes element e = k + A*floor(j/C), where C = SEW/CW, and chunk c = j mod C, low chunk first.
  - regi[k] = e*SEW + c*CW.
  - The slot's low CW bits carry the result; the remaining slot bits are 0.
- Step sequencing:
  - Each rising edge advances one step.
  - Step N-1 is registered with done_out=1 at the same edge, so done rises exactly N edges after start.
  - The final chunk's res/regi/vd remain valid while done_out=1.
- DONE:
  - Outputs hold while run=1.
  - run=0 at an edge -> IDLE with res=0 and done_out=0.
  - A new run needs run low for at least one edge.
- run=0 during BUSY: abort to IDLE at that edge, with res=0 and done_out=0.
- Operand selection:
  - VV: element e of vs1.
  - VX/VI: vs1[SEW-1:0] broadcast to every element.
  - vs2: always element e.
- Operations, per element, modulo 2^SEW:
  - VADD wraps; carry never crosses an element boundary.
  - When SEW > LW, a per-lane carry register chains chunks of the same element and clears at chunk 0.
  - VAND, VOR, VXOR are bitwise.
  - Any other opcode yields result 0 with normal sequencing.

Decomposition:
- Shared package rvv_pkg holds:
  - Opcode localparams: VADD, VAND, VOR, VXOR.
  - op_type encodings: VV, VX, VI.
  - Slot width 64 and regi field width 10.
- One sub-module, rvv_alu_lane:
  - Takes LW-bit operands, opcode, carry-in, and an SEW mask.
  - Produces the LW-bit result and carry-out.
  - It is instantiated 1<<NB_LANES times.
- The wrapper owns the FSM, step counter, operand slicing, regi generation and output registers.

Test Plan:
All cases use defaults (VLEN=128, LANE_WIDTH=3, NB_LANES=1, so 2 lanes × 8 bits and N=8 for every SEW), op_type=VV, VADD, vs1=abcdabcdbeefbeef1234567887654321, vs2=8765432112345678beefbeefabcdabcd.
- vsew=0, run=1: done_out=0 for edges 1..7 and 1 at edge 8. Assembling slots at regi gives 3232eeeed0231467d02314673232eeee. Step 0 shows regi 0/8, res=0011.
- vsew=1, with run low for one edge first: assembled result is 3332eeeed1231567d12315673332eeee, 8 edges.
- vsew=2: assembled result is 3332eeeed1241567d12415673332eeee.
- vsew=3: A=2, lane 1 regi starts at 64. Assembled result is 3332eeeed1241567d12415683332eeee, showing the carry chained across chunks.
- op_type=VX with vs1 = sign-extended 32'h1, vsew=0: every byte of vs2 is incremented by 1. VAND with vsew=0 returns vs1&vs2.
- Deassert resetn mid-BUSY and separately drop run mid-BUSY: outputs go to 0 immediately (async) or at the edge respectively. A fresh run then completes in N edges.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared definitions for the RVV vector ALU sequencer.
// Contents: funct6 opcodes, one-hot op_type encodings, output slot and
// bit-offset field widths, the sequencer state type and a small log2 helper.
package rvv_pkg;

   // funct6 opcodes
   localparam logic [5:0] VADD = 6'b000000;
   localparam logic [5:0] VAND = 6'b001001;
   localparam logic [5:0] VOR  = 6'b001010;
   localparam logic [5:0] VXOR = 6'b001011;

   // one-hot operand types
   localparam logic [2:0] VV = 3'b001;
   localparam logic [2:0] VX = 3'b010;
   localparam logic [2:0] VI = 3'b100;

   // Output slot geometry: four 64-bit result slots, four 10-bit offsets.
   localparam int unsigned SlotW    = 64;
   localparam int unsigned RegiW    = 10;
   localparam int unsigned MaxLanes = 4;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   // Index of the highest set bit; 0 for a zero input.
   function automatic logic [3:0] floor_log2(input logic [RegiW-1:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < RegiW; i++) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rvv_alu_lane.sv
// One ALU lane: processes a Width-bit chunk of a vector element.
// Ports:
//   opcode_i  funct6 operation select
//   a_i, b_i  operand chunks (only bits under mask_i are meaningful)
//   mask_i    ones over the low CW bits actually in use this chunk
//   carry_i   carry from the previous chunk of the same element (VADD only)
//   result_o  masked result chunk; bits above the mask are 0
//   carry_o   carry out of the top lane bit (VADD only, else 0)
module rvv_alu_lane
   import rvv_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic [5:0]       opcode_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic [Width-1:0] mask_i,
   input  logic             carry_i,
   output logic [Width-1:0] result_o,
   output logic             carry_o
);

   logic [Width:0]   sum;
   logic [Width-1:0] raw;

   always_comb begin
      // With a narrow mask the sum cannot reach bit Width, so carry_o is
      // only ever set when a full-width chunk overflows.
      sum     = {1'b0, a_i & mask_i} + {1'b0, b_i & mask_i} + {{Width{1'b0}}, carry_i};
      raw     = '0;
      carry_o = 1'b0;
      case (opcode_i)
         VADD: begin
            raw     = sum[Width-1:0];
            carry_o = sum[Width];
         end
         VAND:    raw = a_i & b_i;
         VOR:     raw = a_i | b_i;
         VXOR:    raw = a_i ^ b_i;
         default: raw = '0;
      endcase
      result_o = raw & mask_i;
   end

endmodule

// File: rtl/rvv_alu_wrapper.sv
// Multi-lane vector ALU sequencer. Streams a VLEN-bit vector through
// 1<<NB_LANES lanes of 1<<LANE_WIDTH bits, one chunk per lane per cycle.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   opcode             funct6 (VADD/VAND/VOR/VXOR, others give 0)
//   run                start/hold; low aborts or returns to idle
//   vs1, vs2           operands (vs1 low bits hold the scalar for VX/VI)
//   vsew               SEW = 8 << vsew
//   op_type            one-hot VV/VX/VI
//   vd                 four 64-bit result slots, lane i at vd[64*i +: 64]
//   regi               four 10-bit destination bit offsets
//   res                per-lane slot valid
//   done_out           final chunk is on the outputs
module rvv_alu_wrapper
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3,
   parameter int unsigned NB_LANES   = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [5:0]                opcode,
   input  logic                      run,
   input  logic [VLEN-1:0]           vs1,
   input  logic [VLEN-1:0]           vs2,
   input  logic [2:0]                vsew,
   input  logic [2:0]                op_type,
   output logic [MaxLanes*SlotW-1:0] vd,
   output logic [MaxLanes*RegiW-1:0] regi,
   output logic [MaxLanes-1:0]       res,
   output logic                      done_out
);

   localparam int unsigned LW     = 1 << LANE_WIDTH;
   localparam int unsigned NL     = 1 << NB_LANES;
   localparam int unsigned PadW   = (VLEN > LW) ? VLEN : LW;
   localparam logic [2:0]  LwLog2 = 3'(LANE_WIDTH);
   localparam logic [3:0]  NlLog2 = 4'(NB_LANES);

   typedef logic [RegiW-1:0] idx_t;

   state_e                    state_q, state_d;
   idx_t                      step_q, step_d;
   logic [NL-1:0]             carry_q, carry_d;
   logic [MaxLanes*SlotW-1:0] vd_q, vd_d;
   logic [MaxLanes*RegiW-1:0] regi_q, regi_d;
   logic [MaxLanes-1:0]       res_q, res_d;
   logic                      done_q, done_d;

   // Step geometry, all powers of two, so kept as log2 values.
   logic [2:0]     log2_sew, log2_cw, log2_c;
   logic [3:0]     log2_a;
   idx_t           num_elem, num_act, last_step, chunk, group, chunk_off;
   logic [LW-1:0]  chunk_mask;
   logic           bcast;

   always_comb begin
      log2_sew   = 3'd3 + vsew;
      log2_cw    = (log2_sew < LwLog2) ? log2_sew : LwLog2;
      log2_c     = log2_sew - log2_cw;
      num_elem   = idx_t'(VLEN >> log2_sew);
      log2_a     = (floor_log2(num_elem) < NlLog2) ? floor_log2(num_elem) : NlLog2;
      num_act    = idx_t'(1) << log2_a;
      last_step  = (idx_t'(VLEN >> log2_cw) >> log2_a) - idx_t'(1);
      // Chunk index is the low log2_c bits of the step, element group the rest.
      chunk      = step_q & ~({RegiW{1'b1}} << log2_c);
      group      = step_q >> log2_c;
      chunk_off  = chunk << log2_cw;
      chunk_mask = ~({LW{1'b1}} << (idx_t'(1) << log2_cw));
      bcast      = (op_type != VV);
   end

   // Per-lane operand slicing.
   idx_t          lane_off [NL];
   logic [LW-1:0] lane_a   [NL];
   logic [LW-1:0] lane_b   [NL];
   logic [LW-1:0] lane_r   [NL];
   logic [NL-1:0] lane_ci, lane_co, lane_act;

   always_comb begin
      for (int k = 0; k < NL; k++) begin
         lane_off[k] = ((idx_t'(k) + (group << log2_a)) << log2_sew) + chunk_off;
         // Scalar operands repeat per element, so only the chunk offset applies.
         lane_a[k]   = LW'(PadW'(vs1) >> (bcast ? chunk_off : lane_off[k]));
         lane_b[k]   = LW'(PadW'(vs2) >> lane_off[k]);
         lane_ci[k]  = (chunk != '0) && carry_q[k];
         lane_act[k] = idx_t'(k) < num_act;
      end
   end

   for (genvar k = 0; k < NL; k++) begin : g_lane
      rvv_alu_lane #(
         .Width (LW)
      ) u_lane (
         .opcode_i (opcode),
         .a_i      (lane_a[k]),
         .b_i      (lane_b[k]),
         .mask_i   (chunk_mask),
         .carry_i  (lane_ci[k]),
         .result_o (lane_r[k]),
         .carry_o  (lane_co[k])
      );
   end

   // Output image of the current step.
   logic [MaxLanes*SlotW-1:0] step_vd;
   logic [MaxLanes*RegiW-1:0] step_regi;
   logic [MaxLanes-1:0]       step_res;

   always_comb begin
      step_vd   = '0;
      step_regi = '0;
      step_res  = '0;
      for (int k = 0; k < NL; k++) begin
         if (lane_act[k]) begin
            step_vd[SlotW*k +: LW]     = lane_r[k];
            step_regi[RegiW*k +: RegiW] = lane_off[k];
            step_res[k]                 = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      carry_d = carry_q;
      vd_d    = vd_q;
      regi_d  = regi_q;
      res_d   = res_q;
      done_d  = done_q;
      case (state_q)
         StIdle: begin
            if (run) begin
               vd_d    = step_vd;
               regi_d  = step_regi;
               res_d   = step_res;
               carry_d = lane_co;
               step_d  = idx_t'(1);
               if (last_step == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StBusy;
                  done_d  = 1'b0;
               end
            end
         end
         StBusy: begin
            if (!run) begin
               state_d = StIdle;
               step_d  = '0;
               carry_d = '0;
               vd_d    = '0;
               regi_d  = '0;
               res_d   = '0;
               done_d  = 1'b0;
            end else begin
               vd_d    = step_vd;
               regi_d  = step_regi;
               res_d   = step_res;
               carry_d = lane_co;
               step_d  = step_q + idx_t'(1);
               if (step_q == last_step) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            // StDone: hold while run stays high.
            if (!run) begin
               state_d = StIdle;
               step_d  = '0;
               carry_d = '0;
               vd_d    = '0;
               regi_d  = '0;
               res_d   = '0;
               done_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         step_q  <= '0;
         carry_q <= '0;
         vd_q    <= '0;
         regi_q  <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         vd_q    <= vd_d;
         regi_q  <= regi_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign vd       = vd_q;
   assign regi     = regi_q;
   assign res      = res_q;
   assign done_out = done_q;

endmodule

// File: tb/tb_rvv_alu_wrapper.sv
// Bench for rvv_alu_wrapper at default geometry (VLEN=128, 2 lanes x 8 bits).
module tb_rvv_alu_wrapper;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_AND = 6'b001001;
   localparam logic [5:0] OP_OR  = 6'b001010;
   localparam logic [5:0] OP_XOR = 6'b001011;
   localparam logic [2:0] T_VV   = 3'b001;
   localparam logic [2:0] T_VX   = 3'b010;
   localparam logic [2:0] T_VI   = 3'b100;
   localparam logic [127:0] VA   = 128'habcdabcdbeefbeef1234567887654321;
   localparam logic [127:0] VB   = 128'h8765432112345678beefbeefabcdabcd;

   logic         clk;
   logic         resetn;
   logic [5:0]   opcode;
   logic         run;
   logic [127:0] vs1;
   logic [127:0] vs2;
   logic [2:0]   vsew;
   logic [2:0]   op_type;
   logic [255:0] vd;
   logic [39:0]  regi;
   logic [3:0]   res;
   logic         done_out;

   int checks = 0;
   int passes = 0;

   rvv_alu_wrapper #(
      .VLEN       (128),
      .LANE_WIDTH (3),
      .NB_LANES   (1)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .opcode   (opcode),
      .run      (run),
      .vs1      (vs1),
      .vs2      (vs2),
      .vsew     (vsew),
      .op_type  (op_type),
      .vd       (vd),
      .regi     (regi),
      .res      (res),
      .done_out (done_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Whole-vector reference result, element by element.
   function automatic logic [127:0] model(input logic [5:0] op, input logic [2:0] ot,
                                          input int sew, input logic [127:0] a_v,
                                          input logic [127:0] b_v);
      logic [127:0] r;
      logic [63:0]  m, a, b, x;
      r = '0;
      m = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
      for (int e = 0; e < 128 / sew; e++) begin
         a = (ot == T_VV) ? (64'(a_v >> (e * sew)) & m) : (64'(a_v) & m);
         b = 64'(b_v >> (e * sew)) & m;
         case (op)
            OP_ADD:  x = (a + b) & m;
            OP_AND:  x = a & b;
            OP_OR:   x = a | b;
            OP_XOR:  x = a ^ b;
            default: x = '0;
         endcase
         r = r | (128'(x) << (e * sew));
      end
      return r;
   endfunction

   // Runs one full operation from idle and checks every step against the model.
   task automatic run_op(input string name, input logic [5:0] op, input logic [2:0] ot,
                         input logic [2:0] sel, input logic [127:0] a_v,
                         input logic [127:0] b_v, output logic [127:0] asm);
      int sew, cw, na, c, n, e, off;
      logic [127:0] mr;
      logic [63:0]  cwm;
      logic [255:0] exp_vd;
      logic [39:0]  exp_regi;
      logic [3:0]   exp_res;
      sew = 8 << sel;
      cw  = (sew < 8) ? sew : 8;
      na  = ((128 / sew) < 2) ? (128 / sew) : 2;
      c   = sew / cw;
      n   = (128 / cw) / na;
      cwm = (cw == 64) ? '1 : ((64'd1 << cw) - 64'd1);
      mr  = model(op, ot, sew, a_v, b_v);
      asm = '0;
      exp_vd = '0;
      opcode = op; op_type = ot; vsew = sel; vs1 = a_v; vs2 = b_v;
      run = 1'b1;
      for (int j = 0; j < n; j++) begin
         @(posedge clk); #1;
         exp_vd = '0; exp_regi = '0; exp_res = '0;
         for (int k = 0; k < na; k++) begin
            e   = k + na * (j / c);
            off = e * sew + (j % c) * cw;
            exp_vd[64*k +: 64]   = 64'(mr >> off) & cwm;
            exp_regi[10*k +: 10] = 10'(off);
            exp_res[k]           = 1'b1;
         end
         checks++;
         if (res !== exp_res) $display("FAIL %s step%0d res got %b want %b", name, j, res, exp_res);
         else passes++;
         checks++;
         if (regi !== exp_regi) $display("FAIL %s step%0d regi got %h want %h", name, j, regi, exp_regi);
         else passes++;
         checks++;
         if (vd !== exp_vd) $display("FAIL %s step%0d vd got %h want %h", name, j, vd, exp_vd);
         else passes++;
         checks++;
         if (done_out !== (j == n - 1)) $display("FAIL %s step%0d done got %b want %b", name, j, done_out, (j == n - 1));
         else passes++;
         for (int k = 0; k < 4; k++) begin
            if (res[k] === 1'b1) asm = asm | (128'(vd[64*k +: 64] & cwm) << regi[10*k +: 10]);
         end
      end
      // Held in DONE while run stays high.
      @(posedge clk); #1;
      checks++;
      if (done_out !== 1'b1 || vd !== exp_vd || res !== exp_res)
         $display("FAIL %s hold got done=%b vd=%h want done=1 vd=%h", name, done_out, vd, exp_vd);
      else passes++;
      run = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (res !== 4'b0 || done_out !== 1'b0)
         $display("FAIL %s release got res=%b done=%b want res=0 done=0", name, res, done_out);
      else passes++;
      checks++;
      if (asm !== mr) $display("FAIL %s assembled got %h want %h", name, asm, mr);
      else passes++;
   endtask

   task automatic test_reset;
      resetn = 1'b0; run = 1'b0; opcode = OP_ADD; op_type = T_VV;
      vsew = 3'd0; vs1 = VA; vs2 = VB;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (vd !== '0 || regi !== '0 || res !== '0 || done_out !== 1'b0)
         $display("FAIL reset got vd=%h regi=%h res=%b done=%b want all 0", vd, regi, res, done_out);
      else passes++;
      run = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res !== '0 || done_out !== 1'b0)
         $display("FAIL reset_hold got res=%b done=%b want 0 0", res, done_out);
      else passes++;
      @(negedge clk);
      run = 1'b0;
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res !== '0 || done_out !== 1'b0)
         $display("FAIL idle got res=%b done=%b want 0 0", res, done_out);
      else passes++;
   endtask

   task automatic test_vadd_sew;
      logic [127:0] lit [4];
      logic [127:0] asm;
      lit[0] = 128'h3232eeeed0231467d02314673232eeee;
      lit[1] = 128'h3332eeeed1231567d12315673332eeee;
      lit[2] = 128'h3332eeeed1241567d12415673332eeee;
      lit[3] = 128'h3332eeeed1241567d12415683332eeee;
      for (int s = 0; s < 4; s++) begin
         run_op("vadd_sew", OP_ADD, T_VV, 3'(s), VA, VB, asm);
         checks++;
         if (asm !== lit[s]) $display("FAIL vadd_sew%0d literal got %h want %h", s, asm, lit[s]);
         else passes++;
      end
   endtask

   task automatic test_scalar_and;
      logic [127:0] asm;
      run_op("vx_inc", OP_ADD, T_VX, 3'd0, 128'h1, VB, asm);
      checks++;
      if (asm !== 128'h8866442213355779bff0bff0acceacce)
         $display("FAIL vx_inc literal got %h want %h", asm, 128'h8866442213355779bff0bff0acceacce);
      else passes++;
      run_op("vand", OP_AND, T_VV, 3'd0, VA, VB, asm);
      checks++;
      if (asm !== (VA & VB)) $display("FAIL vand literal got %h want %h", asm, VA & VB);
      else passes++;
   endtask

   task automatic test_random;
      logic [5:0]   ops [5];
      logic [2:0]   ots [3];
      logic [127:0] a_v, b_v, asm;
      logic [31:0]  sc;
      logic [4:0]   imm;
      logic [2:0]   ot;
      ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_OR; ops[3] = OP_XOR; ops[4] = 6'b111111;
      ots[0] = T_VV; ots[1] = T_VX; ots[2] = T_VI;
      for (int i = 0; i < 10; i++) begin
         ot  = ots[$urandom_range(0, 2)];
         b_v = {$urandom, $urandom, $urandom, $urandom};
         sc  = $urandom;
         imm = 5'($urandom);
         if (ot == T_VV) a_v = {$urandom, $urandom, $urandom, $urandom};
         else if (ot == T_VX) a_v = {{96{sc[31]}}, sc};
         else a_v = {{123{imm[4]}}, imm};
         run_op("random", ops[$urandom_range(0, 4)], ot, 3'($urandom_range(0, 3)), a_v, b_v, asm);
      end
   endtask

   task automatic test_abort;
      logic [127:0] asm;
      opcode = OP_ADD; op_type = T_VV; vsew = 3'd3; vs1 = VA; vs2 = VB;
      run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (vd !== '0 || regi !== '0 || res !== '0 || done_out !== 1'b0)
         $display("FAIL abort got vd=%h regi=%h res=%b done=%b want all 0", vd, regi, res, done_out);
      else passes++;
      run_op("after_abort", OP_ADD, T_VV, 3'd3, VA, VB, asm);
   endtask

   task automatic test_async_reset;
      logic [127:0] asm;
      opcode = OP_XOR; op_type = T_VV; vsew = 3'd1; vs1 = VA; vs2 = VB;
      run = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      resetn = 1'b0;
      run = 1'b0;
      #1;
      checks++;
      if (vd !== '0 || regi !== '0 || res !== '0 || done_out !== 1'b0)
         $display("FAIL async_reset got vd=%h regi=%h res=%b done=%b want all 0", vd, regi, res, done_out);
      else passes++;
      @(negedge clk);
      resetn = 1'b1;
      run_op("after_reset", OP_ADD, T_VV, 3'd2, VA, VB, asm);
   endtask

   initial begin
      test_reset();
      test_vadd_sew();
      test_scalar_and();
      test_random();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
